branch_predictor: RTL



---
 rtl/branch_predictor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of 2-bit counters and targets.
// Combinational lookup for IF; trained by branches resolved in ID.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - IDX_W - 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam logic [1:0]       CTR_RST   = 2'b01;
    localparam logic [1:0]       CTR_ALLOC = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             wr_en;
    logic [1:0]       ctr_d;
    logic [ADDR_W-1:0] tgt_d;

    // Byte-offset bits of the PCs carry no information for lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign rd_idx = pc_i[IDX_W+1:2];
    assign rd_tag = pc_i[ADDR_W-1:IDX_W+2];
    assign wr_idx = upd_pc_i[IDX_W+1:2];
    assign wr_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Lookup: read pre-update contents, no bypass from a same-cycle write.
    always_comb begin
        hit_o         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken_o  = hit_o && ctr_q[rd_idx][1];
        pred_target_o = pred_taken_o ? tgt_q[rd_idx]
                                     : pc_i + ADDR_W'(4);
    end

    // Training: saturating counter step on hit, allocate on taken miss.
    always_comb begin
        wr_en = 1'b0;
        ctr_d = ctr_q[wr_idx];
        tgt_d = tgt_q[wr_idx];
        if (upd_valid_i) begin
            if (wr_hit) begin
                wr_en = 1'b1;
                if (upd_taken_i) begin
                    ctr_d = (ctr_q[wr_idx] == 2'b11) ? 2'b11
                          : ctr_q[wr_idx] + 2'b01;
                    tgt_d = upd_target_i;
                end else begin
                    ctr_d = (ctr_q[wr_idx] == 2'b00) ? 2'b00
                          : ctr_q[wr_idx] - 2'b01;
                end
            end else if (upd_taken_i) begin
                wr_en = 1'b1;
                ctr_d = CTR_ALLOC;
                tgt_d = upd_target_i;
            end
        end
    end

    // Flush request and the correct fetch address for the flush.
    always_comb begin
        mispredict_o  = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && upd_pred_taken_i &&
                          (upd_pred_target_i != upd_target_i)));
        redirect_pc_o = upd_taken_i ? upd_target_i
                                    : upd_pc_i + ADDR_W'(4);
    end

    // Saturating statistics counters.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_valid_i && branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict_o && miss_cnt_q != CNT_MAX) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    // Table storage; reset overrides any concurrent update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_RST;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= tgt_d;
            ctr_q[wr_idx]   <= ctr_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
